// File: rtl/pwr_integ_pkg.sv
// Shared definitions for the power integrator: FSM state type, output width,
// end-to-end latency and the window-length helper.
package pwr_integ_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned OUT_W   = 32;
    // Registers from a sample presented with din_valid to pwr_valid.
    localparam int unsigned LATENCY = 4;
    localparam int unsigned LEN_W   = 16;

    // A programmed length of zero behaves as a one-sample window.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/pwr_sq_sum.sv
// Squaring pipeline: registers I/Q, squares each, then sums I*I + Q*Q.
// Ports:
//   clk, rst (async active-low)
//   en         - low flushes the valid chain so in-flight samples are dropped
//   din_valid  - din_i/din_q valid this cycle
//   din_i/q    - signed IN_W samples
//   sum        - unsigned 2*IN_W sum of squares (lossless)
//   sum_valid  - sum is valid, LATENCY-1 cycles after din_valid
module pwr_sq_sum
    import pwr_integ_pkg::*;
#(
    parameter int unsigned IN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   din_valid,
    input  logic signed [IN_W-1:0] din_i,
    input  logic signed [IN_W-1:0] din_q,
    output logic [2*IN_W-1:0]      sum,
    output logic                   sum_valid
);

    localparam int unsigned SQ_W   = 2 * IN_W;
    localparam int unsigned STAGES = LATENCY - 1;

    logic signed [IN_W-1:0] i_q;
    logic signed [IN_W-1:0] q_q;
    logic [SQ_W-1:0]        ii_q;
    logic [SQ_W-1:0]        qq_q;
    logic [STAGES-1:0]      vld_q;

    logic signed [SQ_W-1:0] i_ext_c;
    logic signed [SQ_W-1:0] q_ext_c;
    logic signed [SQ_W-1:0] ii_c;
    logic signed [SQ_W-1:0] qq_c;

    // Sign-extend before multiplying so the product is a full-width signed square.
    always_comb begin
        i_ext_c = SQ_W'(i_q);
        q_ext_c = SQ_W'(q_q);
        ii_c    = i_ext_c * i_ext_c;
        qq_c    = q_ext_c * q_ext_c;
    end

    // Stage 1 input regs, stage 2 squares, stage 3 sum; valid chain alongside.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_q   <= '0;
            q_q   <= '0;
            ii_q  <= '0;
            qq_q  <= '0;
            sum   <= '0;
            vld_q <= '0;
        end else begin
            i_q   <= din_i;
            q_q   <= din_q;
            ii_q  <= $unsigned(ii_c);
            qq_q  <= $unsigned(qq_c);
            sum   <= ii_q + qq_q;
            vld_q <= en ? {vld_q[STAGES-2:0], din_valid} : '0;
        end
    end

    assign sum_valid = vld_q[STAGES-1];

endmodule

// File: rtl/pwr_integ_32bit.sv
// Windowed power integrator: accumulates I*I + Q*Q over int_len valid samples
// and emits the (shifted) window total on a 32-bit output.
// Ports:
//   clk, rst (async active-low, release synchronised internally)
//   en         - integration enable; low aborts the current window
//   int_len    - samples per window (0 treated as 1), latched per window
//   din_valid, din_i, din_q - signed sample input
//   pwr_out    - window total >> SHIFT, held between pulses
//   pwr_valid  - one-cycle pulse when pwr_out updates
//   ovf        - sticky: a shifted window total exceeded 32 bits
// Build option: define PWR_INTEG_SAT_EN to saturate pwr_out to all-ones on
// overflow; otherwise pwr_out carries the low 32 bits.
module pwr_integ_32bit
    import pwr_integ_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [LEN_W-1:0]       int_len,
    input  logic                   din_valid,
    input  logic signed [IN_W-1:0] din_i,
    input  logic signed [IN_W-1:0] din_q,
    output logic [OUT_W-1:0]       pwr_out,
    output logic                   pwr_valid,
    output logic                   ovf
);

    localparam int unsigned SQ_W = 2 * IN_W;
    // Total width always leaves room above OUT_W for the overflow test.
    localparam int unsigned TW   = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

    logic [1:0]        sync_q;
    logic              rst_ok;
    logic              en_eff;

    logic [SQ_W-1:0]   sum;
    logic              sum_valid;

    state_t            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;

    logic [LEN_W-1:0]  len_start_c;
    logic [LEN_W-1:0]  len_cur_c;
    logic              done_c;
    logic [TW-1:0]     total_c;
    logic [TW-1:0]     shifted_c;
    logic              ovf_c;
    logic [OUT_W-1:0]  out_c;

    // Assert asynchronously, release two edges later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_ok = sync_q[1];
    assign en_eff = en & rst_ok;

    pwr_sq_sum #(
        .IN_W(IN_W)
    ) u_sq (
        .clk      (clk),
        .rst      (rst),
        .en       (en_eff),
        .din_valid(din_valid),
        .din_i    (din_i),
        .din_q    (din_q),
        .sum      (sum),
        .sum_valid(sum_valid)
    );

    // Window bookkeeping: the first sum of a window uses the live int_len.
    always_comb begin
        len_start_c = eff_len(int_len);
        len_cur_c   = (cnt_q == '0) ? len_start_c : len_q;
        done_c      = ({1'b0, cnt_q} + (LEN_W+1)'(1)) >= {1'b0, len_cur_c};
        total_c     = TW'(acc_q) + TW'(sum);
        shifted_c   = total_c >> SHIFT;
        ovf_c       = |shifted_c[TW-1:OUT_W];
`ifdef PWR_INTEG_SAT_EN
        out_c       = ovf_c ? '1 : shifted_c[OUT_W-1:0];
`else
        out_c       = shifted_c[OUT_W-1:0];
`endif
    end

    // Control FSM with accumulator, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= LEN_W'(1);
            pwr_out   <= '0;
            pwr_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            pwr_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (en_eff) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!en_eff) begin
                        // Abort: partial window discarded, pwr_out holds.
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else if (sum_valid) begin
                        if (cnt_q == '0) begin
                            len_q <= len_start_c;
                        end
                        if (done_c) begin
                            acc_q     <= '0;
                            cnt_q     <= '0;
                            pwr_out   <= out_c;
                            pwr_valid <= 1'b1;
                            ovf       <= ovf | ovf_c;
                        end else begin
                            acc_q <= ACC_W'(total_c);
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
